// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-FF synchroniser, then a tick-strobed FSM that accepts a
// level change only after STABLE_TICKS consecutive equal samples.
module button_debouncer #(
  parameter int STABLE_TICKS = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   btn_in,
  output logic                   btn_level,
  output logic                   pressed,
  output logic                   released,
  output logic [COUNT_WIDTH-1:0] press_count
);

  localparam int CW = (STABLE_TICKS < 1) ? 1 : $clog2(STABLE_TICKS + 1);
  localparam logic REL_LVL = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_TICKS - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [1:0]             sync_q;
  logic                   s;
  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   pressed_q;
  logic                   released_q;
  logic [COUNT_WIDTH-1:0] count_q;

  // Synchroniser idles at the released pin level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{REL_LVL}};
    end else begin
      sync_q <= {sync_q[0], btn_in};
    end
  end

  assign s = sync_q[1] ^ REL_LVL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      if (tick) begin
        case (state_q)
          IDLE: begin
            if (s) begin
              if (STABLE_TICKS == 1) begin
                state_q   <= HELD;
                cnt_q     <= '0;
                level_q   <= 1'b1;
                pressed_q <= 1'b1;
                count_q   <= count_q + 1'b1;
              end else begin
                state_q <= PRESS_WAIT;
                cnt_q   <= ONE_CNT;
              end
            end
          end
          PRESS_WAIT: begin
            if (s) begin
              if (cnt_q == LAST_CNT) begin
                state_q   <= HELD;
                cnt_q     <= '0;
                level_q   <= 1'b1;
                pressed_q <= 1'b1;
                count_q   <= count_q + 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
          HELD: begin
            if (!s) begin
              if (STABLE_TICKS == 1) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                level_q    <= 1'b0;
                released_q <= 1'b1;
              end else begin
                state_q <= RELEASE_WAIT;
                cnt_q   <= ONE_CNT;
              end
            end
          end
          RELEASE_WAIT: begin
            if (!s) begin
              if (cnt_q == LAST_CNT) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                level_q    <= 1'b0;
                released_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else begin
              state_q <= HELD;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign btn_level   = level_q;
  assign pressed     = pressed_q;
  assign released    = released_q;
  assign press_count = count_q;

endmodule
